// File: rtl/agc_mem_arbiter.sv
// rtl/agc_mem_arbiter.sv - AGC data memory arbiter: CPU single accesses and atomic counter read-modify-write
// Optional feature macro: AGC_ARB_FAIRNESS_EN (CPU gets a slot between consecutive counter updates)
module agc_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [14:0] cpu_wdata,
    output logic [14:0] cpu_rdata,
    output logic        cpu_done,
    input  logic        ctr_req,
    input  logic        ctr_dir,
    input  logic [11:0] ctr_addr,
    output logic        ctr_ack,
    output logic        ctr_ovf,
    output logic        fault,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [14:0] mem_din,
    input  logic [14:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ACC,
        S_CPU_RSP,
        S_CTR_RD,
        S_CTR_CALC,
        S_CTR_WB,
        S_CTR_RSP
    } state_t;

    state_t      state;
    logic        dir_q;
    logic        blocked_q;
    logic        ovf_q;
    logic        mem_we_q;
    logic [11:0] mem_addr_q;
    // Holds CPU write data, and the counter result register once CTR_CALC has run
    logic [14:0] mem_din_q;
    logic        cpu_done_q;
    logic        ctr_ack_q;
    logic        ctr_ovf_q;
    logic        fault_q;
`ifdef AGC_ARB_FAIRNESS_EN
    logic        fair_q;
`endif

    logic        cpu_win;
    logic [14:0] inc_val;
    logic [15:0] raw_sum;
    logic [14:0] calc_val;
    logic        calc_ovf;

    // Fixed memory (addr >= 12'h400) and the zero register are read-only
    function automatic logic is_writable(input logic [11:0] a);
        return (a[11:10] == 2'b00) && (a != 12'h007);
    endfunction

    // Arbitration between simultaneous requests in IDLE
    always_comb begin
        cpu_win = 1'b0;
`ifdef AGC_ARB_FAIRNESS_EN
        cpu_win = cpu_req && (!ctr_req || fair_q);
`else
        cpu_win = cpu_req && !ctr_req;
`endif
    end

    // Ones' complement +1 / -1 with end-around carry, plus the two overflow corners
    always_comb begin
        inc_val  = dir_q ? 15'h7FFE : 15'h0001;
        raw_sum  = {1'b0, mem_dout} + {1'b0, inc_val};
        calc_val = raw_sum[14:0] + {14'b0, raw_sum[15]};
        calc_ovf = 1'b0;
        if (!dir_q && mem_dout == 15'h3FFF) begin
            calc_val = 15'h0000;
            calc_ovf = 1'b1;
        end else if (dir_q && mem_dout == 15'h4000) begin
            calc_val = 15'h7FFF;
            calc_ovf = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dir_q      <= 1'b0;
            blocked_q  <= 1'b0;
            ovf_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 12'h000;
            mem_din_q  <= 15'h0000;
            cpu_done_q <= 1'b0;
            ctr_ack_q  <= 1'b0;
            ctr_ovf_q  <= 1'b0;
            fault_q    <= 1'b0;
`ifdef AGC_ARB_FAIRNESS_EN
            fair_q     <= 1'b0;
`endif
        end else begin
            cpu_done_q <= 1'b0;
            ctr_ack_q  <= 1'b0;
            ctr_ovf_q  <= 1'b0;
            fault_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_win) begin
                        mem_addr_q <= cpu_addr;
                        mem_din_q  <= cpu_wdata;
                        mem_we_q   <= cpu_we && is_writable(cpu_addr);
                        blocked_q  <= cpu_we && !is_writable(cpu_addr);
                        state      <= S_CPU_ACC;
                    end else if (ctr_req) begin
                        mem_addr_q <= ctr_addr;
                        dir_q      <= ctr_dir;
                        blocked_q  <= !is_writable(ctr_addr);
                        state      <= S_CTR_RD;
                    end
                end
                S_CPU_ACC: begin
                    cpu_done_q <= 1'b1;
                    fault_q    <= blocked_q;
                    state      <= S_CPU_RSP;
                end
                S_CPU_RSP: begin
`ifdef AGC_ARB_FAIRNESS_EN
                    fair_q <= 1'b0;
`endif
                    state  <= S_IDLE;
                end
                S_CTR_RD: begin
                    state <= S_CTR_CALC;
                end
                S_CTR_CALC: begin
                    mem_din_q <= calc_val;
                    ovf_q     <= calc_ovf;
                    mem_we_q  <= !blocked_q;
                    state     <= S_CTR_WB;
                end
                S_CTR_WB: begin
                    ctr_ack_q <= 1'b1;
                    ctr_ovf_q <= ovf_q;
                    fault_q   <= blocked_q;
                    state     <= S_CTR_RSP;
                end
                S_CTR_RSP: begin
`ifdef AGC_ARB_FAIRNESS_EN
                    fair_q <= 1'b1;
`endif
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset kills an in-flight write in the same cycle it is asserted
    assign mem_we    = mem_we_q & ~reset;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_done_q ? mem_dout : 15'h0000;
    assign ctr_ack   = ctr_ack_q;
    assign ctr_ovf   = ctr_ovf_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// tb/tb_agc_mem_arbiter.sv - self-checking bench for agc_mem_arbiter
module tb_agc_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [14:0] cpu_wdata, cpu_rdata;
    logic        cpu_done;
    logic        ctr_req, ctr_dir;
    logic [11:0] ctr_addr;
    logic        ctr_ack, ctr_ovf, fault;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [14:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    agc_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .ctr_req(ctr_req), .ctr_dir(ctr_dir), .ctr_addr(ctr_addr),
        .ctr_ack(ctr_ack), .ctr_ovf(ctr_ovf), .fault(fault),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory model: registered read, write-first
    logic [14:0] mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h000;
    logic [14:0] pre_data = 15'h0000;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
        end else begin
            mem_dout <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          is_ctr;
        logic [14:0] rdata;
        bit          ovf;
        bit          fault;
    } exp_t;

    typedef struct {
        bit          is_ctr;
        bit          we;
        bit          dir;
        logic [11:0] addr;
        logic [14:0] wdata;
        bit          do_pre;
        logic [14:0] pre;
        logic [14:0] exp_rdata;
        bit          exp_ovf;
        bit          exp_fault;
        int          exp_writes;
        logic [14:0] exp_cell;
    } vec_t;

    exp_t sb[$];
    bit   kinds[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit tb_writable(input logic [11:0] a);
        return (a < 12'h400) && (a != 12'h007);
    endfunction

    // One cycle: advance to the negedge and check whatever the DUT presents
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mem_we) begin
            wr_count++;
            chk("we_writable", {63'b0, tb_writable(mem_addr)}, 64'd1);
        end
        if (fault) chk("fault_with_done", {63'b0, cpu_done | ctr_ack}, 64'd1);
        if (cpu_done || ctr_ack) begin
            kinds.push_back(ctr_ack);
            chk("single_completion", {63'b0, cpu_done & ctr_ack}, 64'd0);
            chk("sb_pending", {63'b0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("kind", {63'b0, ctr_ack}, {63'b0, e.is_ctr});
                chk("fault", {63'b0, fault}, {63'b0, e.fault});
                if (e.is_ctr) chk("ctr_ovf", {63'b0, ctr_ovf}, {63'b0, e.ovf});
                else          chk("cpu_rdata", {49'b0, cpu_rdata}, {49'b0, e.rdata});
            end
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [14:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int w0;
        if (v.do_pre) preload(v.addr, v.pre);
        tick();
        w0 = wr_count;
        sb.push_back('{v.is_ctr, v.exp_rdata, v.exp_ovf, v.exp_fault});
        if (v.is_ctr) begin
            ctr_req = 1'b1; ctr_dir = v.dir; ctr_addr = v.addr;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!(v.is_ctr ? ctr_ack : cpu_done) && n < 20);
        chk(v.is_ctr ? "ctr_latency" : "cpu_latency", n, v.is_ctr ? 4 : 2);
        cpu_req = 1'b0;
        ctr_req = 1'b0;
        chk("write_count", wr_count - w0, v.exp_writes);
        chk("cell", {49'b0, mem[v.addr]}, {49'b0, v.exp_cell});
    endtask

    vec_t vecs[11];
    bit   exp_kind[3];
    logic [14:0] exp_arb_cell;

    initial begin
        int n;
        int k0;
        //        ctr we dir addr    wdata     pre pre_val   rdata     ovf flt wr cell
        vecs[0]  = '{0, 1, 0, 12'h010, 15'h1234, 0, 15'h0000, 15'h1234, 0, 0, 1, 15'h1234};
        vecs[1]  = '{0, 0, 0, 12'h010, 15'h0000, 0, 15'h0000, 15'h1234, 0, 0, 0, 15'h1234};
        vecs[2]  = '{0, 1, 0, 12'h007, 15'h5555, 1, 15'h0AAA, 15'h0AAA, 0, 1, 0, 15'h0AAA};
        vecs[3]  = '{0, 1, 0, 12'h400, 15'h5555, 1, 15'h0BBB, 15'h0BBB, 0, 1, 0, 15'h0BBB};
        vecs[4]  = '{0, 0, 0, 12'h007, 15'h0000, 0, 15'h0000, 15'h0AAA, 0, 0, 0, 15'h0AAA};
        vecs[5]  = '{1, 0, 0, 12'h020, 15'h0000, 1, 15'h3FFF, 15'h0000, 1, 0, 1, 15'h0000};
        vecs[6]  = '{1, 0, 1, 12'h020, 15'h0000, 1, 15'h0000, 15'h0000, 0, 0, 1, 15'h7FFE};
        vecs[7]  = '{1, 0, 1, 12'h020, 15'h0000, 1, 15'h4000, 15'h0000, 1, 0, 1, 15'h7FFF};
        vecs[8]  = '{1, 0, 0, 12'h020, 15'h0000, 1, 15'h7FFF, 15'h0000, 0, 0, 1, 15'h0001};
        vecs[9]  = '{1, 0, 0, 12'h007, 15'h0000, 1, 15'h0005, 15'h0000, 0, 1, 0, 15'h0005};
        vecs[10] = '{1, 0, 0, 12'h020, 15'h0000, 1, 15'h0123, 15'h0000, 0, 0, 1, 15'h0124};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 15'h0000;
        ctr_req = 1'b0; ctr_dir = 1'b0; ctr_addr = 12'h000;
        repeat (3) tick();
        chk("reset_outputs", {cpu_rdata, cpu_done, ctr_ack, ctr_ovf, fault, mem_we, mem_addr, mem_din}, 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Clears the fairness flag left set by the last counter update
        run_vec('{0, 0, 0, 12'h010, 15'h0000, 0, 15'h0000, 15'h1234, 0, 0, 0, 15'h1234});

        // Both requests held for three transactions
        preload(12'h030, 15'h0000);
        tick();
`ifdef AGC_ARB_FAIRNESS_EN
        exp_kind = '{1'b1, 1'b0, 1'b1};
        exp_arb_cell = 15'h0002;
`else
        exp_kind = '{1'b1, 1'b1, 1'b1};
        exp_arb_cell = 15'h0003;
`endif
        begin
            logic [14:0] cnt;
            cnt = 15'h0000;
            for (int i = 0; i < 3; i++) begin
                if (exp_kind[i]) begin
                    sb.push_back('{1'b1, 15'h0000, 1'b0, 1'b0});
                    cnt = cnt + 15'h0001;
                end else begin
                    sb.push_back('{1'b0, 15'h1234, 1'b0, 1'b0});
                end
            end
        end
        k0 = kinds.size();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        ctr_req = 1'b1; ctr_dir = 1'b0; ctr_addr = 12'h030;
        n = 0;
        while (kinds.size() - k0 < 3 && n < 40) begin
            tick();
            n++;
        end
        cpu_req = 1'b0;
        ctr_req = 1'b0;
        chk("arb_completions", kinds.size() - k0, 3);
        for (int i = 0; i < 3; i++)
            if (k0 + i < kinds.size())
                chk($sformatf("arb_order_%0d", i), {63'b0, kinds[k0 + i]}, {63'b0, exp_kind[i]});
        chk("arb_cell", {49'b0, mem[12'h030]}, {49'b0, exp_arb_cell});

        // Reset asserted in CTR_WB must suppress the write and the ack
        preload(12'h040, 15'h0005);
        ctr_req = 1'b1; ctr_dir = 1'b0; ctr_addr = 12'h040;
        tick();
        chk("rst_rd_addr", {52'b0, mem_addr}, 64'h040);
        tick();
        tick();
        chk("rst_wb_we", {63'b0, mem_we}, 64'd1);
        reset = 1'b1;
        ctr_req = 1'b0;
        #1;
        chk("rst_we_gated", {63'b0, mem_we}, 64'd0);
        tick();
        chk("rst_outputs", {cpu_rdata, cpu_done, ctr_ack, ctr_ovf, fault, mem_we, mem_addr, mem_din}, 64'd0);
        chk("rst_cell", {49'b0, mem[12'h040]}, 64'h0005);
        reset = 1'b0;
        repeat (6) tick();
        chk("rst_cell_after", {49'b0, mem[12'h040]}, 64'h0005);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/agc_mem_arbiter.md
# agc_mem_arbiter

Sequencer and arbiter in front of the AGC data memory: shares the single 12-bit-address, 15-bit-word memory port between the CPU control unit and the involuntary counter unit (PINC/MINC cell updates). CPU reads and writes pass through as single accesses. Counter requests are serviced as atomic read-modify-write sequences using 15-bit ones' complement arithmetic. All writes are screened so that fixed memory and the zero register are never written.

## Interface
- No parameters. Address width 12 and word width 15 are fixed by the memory.
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with its operands until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  12  CPU address
- cpu_wdata  in  15  CPU write data
- cpu_rdata  out  15  read data, valid while cpu_done = 1
- cpu_done  out  1  one-cycle completion pulse
- ctr_req  in  1  counter-cell update request; held until ctr_ack
- ctr_dir  in  1  0 = PINC (+1), 1 = MINC (−1)
- ctr_addr  in  12  counter cell address
- ctr_ack  out  1  one-cycle completion pulse
- ctr_ovf  out  1  overflow flag, valid only with ctr_ack
- fault  out  1  one-cycle pulse when a write is suppressed
- mem_we  out  1  memory write enable
- mem_addr  out  12  memory address
- mem_din  out  15  memory write data
- mem_dout  in  15  memory read data; registered at the posedge when mem_addr is applied, so it reflects the post-write contents

## Operation
- States: IDLE, CPU_ACC, CPU_RSP, CTR_RD, CTR_CALC, CTR_WB, CTR_RSP.
- IDLE: the block latches the winning request's operands.
  - cpu_req alone → CPU_ACC.
  - ctr_req alone, or both requests → CTR_RD (see Configuration for fairness).
- CPU_ACC: drives mem_addr = latched address.
  - mem_we = 1 only if this is a write and the address is writable; mem_din = latched data.
  - Next state: CPU_RSP.
- CPU_RSP: cpu_done = 1; cpu_rdata = mem_dout for both reads and writes. Next state: IDLE.
- CTR_RD: mem_addr = ctr address, mem_we = 0. Next state: CTR_CALC.
- CTR_CALC: computes the update from mem_dout and registers it in a 15-bit result register. Next state: CTR_WB.
  - Ones' complement add of 15'h0001 (PINC) or 15'h7FFE (MINC), with end-around carry.
  - PINC of 15'h3FFF: result 15'h0000, ovf = 1.
  - MINC of 15'h4000: result 15'h7FFF, ovf = 1.
  - Otherwise ovf = 0. Examples: PINC of 15'h7FFF (−0) gives 15'h0001; MINC of 15'h0000 gives 15'h7FFE.
- CTR_WB: mem_we = 1 (if writable), mem_addr = ctr address, mem_din = result. Next state: CTR_RSP.
- CTR_RSP: ctr_ack = 1; ctr_ovf = registered ovf. Next state: IDLE.
- Writable address: addr[11:10] == 2'b00 and addr != 12'h007.
  - A write to any other address keeps mem_we = 0, pulses fault in the RSP cycle, and still completes the handshake.
- Counter updates are atomic: no CPU access is interleaved between CTR_RD and CTR_WB.

## Timing
- Reset values: state IDLE; all outputs 0; mem_addr = 0; fairness flag cleared.
- mem_we is gated by !reset. A reset asserted during CTR_WB or CPU_ACC suppresses the write, and the in-flight request is dropped without done or ack.
- CPU latency: request sampled at edge E0; memory accessed at E1; cpu_done high in the cycle after E1. This gives 2 cycles from sample to done, and 3 cycles per CPU transaction including the IDLE cycle.
- Counter latency: sampled at E0; read at E1; calculate until E2; write at E3; ctr_ack high in the cycle after E3. This gives 5 cycles per transaction including IDLE.
- Handshake: a requester must deassert req, or present a new request, by the edge that ends its done/ack cycle. A request still high in the following IDLE is treated as a new request.
- A request arriving while the block is busy waits. No request is lost while req is held.

## Configuration
- AGC_ARB_FAIRNESS_EN defined:
  - A flag is set on every counter completion and cleared on every CPU completion.
  - In IDLE with both requests pending and the flag set, the CPU wins.
  - The CPU therefore gets at least one slot between consecutive counter updates.
- Undefined: strict counter priority; the CPU can be starved while ctr_req stays high.

## Test plan
- CPU write 15'h1234 to 12'h010, then read 12'h010:
  - mem_we pulses once, with mem_addr 12'h010.
  - The read returns cpu_rdata = 15'h1234, with cpu_done 2 cycles after the request is sampled.
- CPU write to 12'h007 and to 12'h400:
  - mem_we stays 0 throughout.
  - fault pulses alongside cpu_done.
  - A subsequent read of 12'h007 returns its unchanged contents.
- Counter with ctr_addr 12'h020:
  - Preload 15'h3FFF, PINC → cell = 15'h0000, ctr_ovf = 1.
  - Preload 15'h0000, MINC → 15'h7FFE, ovf = 0.
  - Preload 15'h4000, MINC → 15'h7FFF, ovf = 1.
- cpu_req and ctr_req asserted together and held for three transactions:
  - Macro undefined: order is ctr, ctr, ctr.
  - Macro defined: order is ctr, cpu, ctr.
- Assert reset during CTR_WB of a PINC on a cell holding 15'h0005:
  - The cell stays 15'h0005.
  - No ctr_ack is issued.
  - All outputs are 0 the cycle after reset.
